ram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared byte-maskable data RAM (`ram_2`). It accepts load/store requests from the core load-store unit (port 0) and the debug/loader port (port 1), then grants one at a time. It validates size and alignment, drives the RAM's single write/read strobe for exactly one cycle, and captures the registered RAM read data. It returns a per-port done/data/error response.

---
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter and sequencer for the shared byte-maskable data RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [3:0]    p0_type,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdat,
  input  logic          p0_sign,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_type,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdat,
  input  logic          p1_sign,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdat,
  output logic          p0_err,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdat,
  output logic          p1_err,
  output logic          ram_we,
  output logic          ram_re,
  output logic [3:0]    ram_type,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdat,
  output logic          ram_sign,
  input  logic [DW-1:0] ram_rdat,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_t;

  state_t        r_state, w_next;
  logic          r_id, r_we, r_err, r_sign;
  logic [3:0]    r_type;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdat, r_p0_rdat, r_p1_rdat;

  logic          w_pick1, w_start, w_we, w_sign, w_type_ok, w_legal;
  logic [3:0]    w_type;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdat;
  logic [1:0]    w_nb_m1;
  logic [2:0]    w_last_byte;

`ifdef RAM_ARB_RR_EN
  // r_last remembers the previous winner; on a tie the other port is served.
  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last <= 1'b1;
    else if (w_start) r_last <= w_pick1;
  end

  assign w_pick1 = p1_req & (~p0_req | ~r_last);
`else
  assign w_pick1 = p1_req & ~p0_req;
`endif

  // Gating with rst keeps gnt low while the block is held in reset.
  assign w_start = (r_state == IDLE) & (p0_req | p1_req) & ~rst;

  assign w_we   = w_pick1 ? p1_we   : p0_we;
  assign w_type = w_pick1 ? p1_type : p0_type;
  assign w_addr = w_pick1 ? p1_addr : p0_addr;
  assign w_wdat = w_pick1 ? p1_wdat : p0_wdat;
  assign w_sign = w_pick1 ? p1_sign : p0_sign;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_nb_m1   = 2'd0;
    w_type_ok = 1'b1;
    case (w_type)
      4'b0001: w_nb_m1 = 2'd0;
      4'b0011: w_nb_m1 = 2'd1;
      4'b0111: w_nb_m1 = 2'd2;
      4'b1111: w_nb_m1 = 2'd3;
      default: w_type_ok = 1'b0;
    endcase
    w_last_byte = {1'b0, w_addr[1:0]} + {1'b0, w_nb_m1};
    w_legal     = w_type_ok & (w_last_byte <= 3'd3);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_legal ? ACCESS : RESP;
      ACCESS:  w_next = r_we ? RESP : RD_WAIT;
      RD_WAIT: w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_type  <= '0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_id   <= w_pick1;
        r_we   <= w_we;
        r_err  <= ~w_legal;
        r_type <= w_type;
        r_addr <= w_addr;
        r_wdat <= w_wdat;
        r_sign <= w_sign;
      end
    end
  end

  // Load data is captured only in RD_WAIT, so store/error completions keep the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_rdat <= '0;
      r_p1_rdat <= '0;
    end else if (r_state == RD_WAIT) begin
      if (r_id) r_p1_rdat <= ram_rdat;
      else      r_p0_rdat <= ram_rdat;
    end
  end

  assign p0_gnt   = w_start & ~w_pick1;
  assign p1_gnt   = w_start &  w_pick1;
  assign p0_done  = (r_state == RESP) & ~r_id;
  assign p1_done  = (r_state == RESP) &  r_id;
  assign p0_err   = p0_done & r_err;
  assign p1_err   = p1_done & r_err;
  assign p0_rdat  = r_p0_rdat;
  assign p1_rdat  = r_p1_rdat;
  assign ram_we   = (r_state == ACCESS) &  r_we;
  assign ram_re   = (r_state == ACCESS) & ~r_we;
  assign ram_type = r_type;
  assign ram_addr = r_addr;
  assign ram_wdat = r_wdat;
  assign ram_sign = r_sign;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a RAM model, a transaction-level reference
// model compared every cycle, and directed transactions with literal expectations.
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 0, p0_we = 0, p0_sign = 0;
  logic [3:0]    p0_type = '0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdat = '0;
  logic          p1_req = 0, p1_we = 0, p1_sign = 0;
  logic [3:0]    p1_type = '0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdat = '0;
  logic          p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [DW-1:0] p0_rdat, p1_rdat;
  logic          ram_we, ram_re, ram_sign, busy;
  logic [3:0]    ram_type;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdat;
  logic [DW-1:0] ram_rdat = '0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_type(p0_type), .p0_addr(p0_addr),
    .p0_wdat(p0_wdat), .p0_sign(p0_sign),
    .p1_req(p1_req), .p1_we(p1_we), .p1_type(p1_type), .p1_addr(p1_addr),
    .p1_wdat(p1_wdat), .p1_sign(p1_sign),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdat(p0_rdat), .p0_err(p0_err),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdat(p1_rdat), .p1_err(p1_err),
    .ram_we(ram_we), .ram_re(ram_re), .ram_type(ram_type), .ram_addr(ram_addr),
    .ram_wdat(ram_wdat), .ram_sign(ram_sign), .ram_rdat(ram_rdat), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [3:0] ty);
    case (ty)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b0111: return 3;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input int nb, input bit sg);
    logic [31:0] v;
    v = raw;
    if (nb > 0 && nb < 4 && sg && raw[8*nb-1]) v = raw | ~((32'h1 << (8*nb)) - 32'h1);
    return v;
  endfunction

  // RAM environment: byte-masked write, registered sign-extended read.
  logic [7:0]  ram_mem [256] = '{default: 8'h00};
  logic [31:0] ram_raw;
  always @(posedge clk) begin
    if (ram_re) begin
      ram_raw = '0;
      for (int i = 0; i < nbytes(ram_type); i++)
        ram_raw[8*i +: 8] = ram_mem[8'(ram_addr[7:0] + 8'(i))];
      ram_rdat <= extend(ram_raw, nbytes(ram_type), ram_sign);
    end
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_type[i]) ram_mem[8'(ram_addr[7:0] + 8'(i))] <= ram_wdat[8*i +: 8];
  end

  // Reference model: transaction age since grant; done after 1 (error), 2 (store) or 3 (load).
  logic [7:0]  ref_mem [256] = '{default: 8'h00};
  int          m_age = -1;
  bit          m_last = 1'b1;
  int          m_port;
  bit          m_we, m_sg, m_legal;
  logic [3:0]  m_ty;
  logic [31:0] m_addr, m_wd;
  logic [31:0] m_rdat [2] = '{32'h0, 32'h0};
  bit          prev_we = 0, prev_re = 0, prev_g = 0, prev_d = 0;
  int          glog [$];

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] ty, input bit sg);
    logic [31:0] raw;
    raw = '0;
    for (int i = 0; i < nbytes(ty); i++) raw[8*i +: 8] = ref_mem[8'(a[7:0] + 8'(i))];
    return extend(raw, nbytes(ty), sg);
  endfunction

  always @(negedge clk) begin
    int win, dur;
    bit done, e_we, e_re;
    if (rst) begin
      check("rst_ctrl", {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, ram_we, ram_re, busy, ram_sign}, '0);
      check("rst_p0_rdat", p0_rdat, '0);
      check("rst_p1_rdat", p1_rdat, '0);
      check("rst_ram_addr", ram_addr, '0);
      check("rst_ram_wdat", ram_wdat, '0);
      check("rst_ram_type", ram_type, '0);
      m_age = -1; m_last = 1'b1; m_rdat[0] = '0; m_rdat[1] = '0;
      prev_we = 0; prev_re = 0; prev_g = 0; prev_d = 0;
    end else begin
      win = -1;
      if (m_age < 0 && (p0_req || p1_req)) begin
`ifdef RAM_ARB_RR_EN
        if (p0_req && p1_req) win = m_last ? 0 : 1;
        else                  win = p0_req ? 0 : 1;
`else
        win = p0_req ? 0 : 1;
`endif
      end
      dur  = !m_legal ? 1 : (m_we ? 2 : 3);
      done = (m_age >= 0) && (m_age == dur);
      e_we = (m_age == 1) && m_legal && m_we;
      e_re = (m_age == 1) && m_legal && !m_we;
      if (done && m_legal && !m_we) m_rdat[m_port] = ref_load(m_addr, m_ty, m_sg);
      if (done && m_legal && m_we)
        for (int i = 0; i < 4; i++)
          if (m_ty[i]) ref_mem[8'(m_addr[7:0] + 8'(i))] = m_wd[8*i +: 8];

      check("gnt", {p0_gnt, p1_gnt}, {win == 0, win == 1});
      check("done", {p0_done, p1_done}, {done && m_port == 0, done && m_port == 1});
      check("strobe", {ram_we, ram_re}, {e_we, e_re});
      check("busy", busy, m_age >= 0);
      check("p0_rdat", p0_rdat, m_rdat[0]);
      check("p1_rdat", p1_rdat, m_rdat[1]);
      if (done) check("err", m_port ? p1_err : p0_err, !m_legal);
      if (e_we || e_re) begin
        check("ram_addr", ram_addr, m_addr);
        check("ram_type_sign", {ram_type, ram_sign}, {m_ty, m_sg});
        if (e_we) check("ram_wdat", ram_wdat, m_wd);
      end
      check("we_re_overlap", ram_we & ram_re, 1'b0);
      check("strobe_width", (ram_we & prev_we) | (ram_re & prev_re), 1'b0);
      check("pulse_width", ((p0_gnt | p1_gnt) & prev_g) | ((p0_done | p1_done) & prev_d), 1'b0);
      prev_we = ram_we; prev_re = ram_re;
      prev_g = p0_gnt | p1_gnt; prev_d = p0_done | p1_done;
      if (p0_gnt) glog.push_back(0);
      else if (p1_gnt) glog.push_back(1);

      if (win >= 0) begin
        m_port = win; m_last = win[0];
        m_we   = win ? p1_we   : p0_we;
        m_ty   = win ? p1_type : p0_type;
        m_addr = win ? p1_addr : p0_addr;
        m_wd   = win ? p1_wdat : p0_wdat;
        m_sg   = win ? p1_sign : p0_sign;
        m_legal = nbytes(m_ty) != 0 && (int'(m_addr % 4) + nbytes(m_ty) <= 4);
        m_age  = 1;
      end else if (m_age >= 0) begin
        m_age = done ? -1 : m_age + 1;
      end
    end
  end

  task automatic drive(input int p, input bit rq, input bit we, input logic [3:0] ty,
                       input logic [31:0] a, input logic [31:0] wd, input bit sg);
    if (p == 0) begin
      p0_req = rq; p0_we = we; p0_type = ty; p0_addr = a; p0_wdat = wd; p0_sign = sg;
    end else begin
      p1_req = rq; p1_we = we; p1_type = ty; p1_addr = a; p1_wdat = wd; p1_sign = sg;
    end
  endtask

  // Issue one request, wait (bounded) for grant and completion; report latency after grant.
  task automatic txn(input int p, input bit we, input logic [3:0] ty, input logic [31:0] a,
                     input logic [31:0] wd, input bit sg,
                     output int lat, output bit err, output logic [31:0] rd);
    bit seen;
    lat = -1; err = 0; rd = '0;
    drive(p, 1, we, ty, a, wd, sg);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = p ? p1_gnt : p0_gnt;
    end
    check("gnt_arrives", seen, 1'b1);
    @(posedge clk); #1;
    drive(p, 0, 0, 4'h0, '0, '0, 0);
    if (!seen) return;
    seen = 0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(negedge clk);
      if (p ? p1_done : p0_done) begin
        seen = 1; lat = n;
        err = p ? p1_err : p0_err;
        rd  = p ? p1_rdat : p0_rdat;
      end
    end
    check("done_arrives", seen, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    bit err;
    logic [31:0] rd;
    int exp_log [4];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("busy_after_reset", busy, 1'b0);

    // Contention: both ports request continuously for four transactions.
    glog.delete();
    drive(0, 1, 0, 4'hf, 32'h0, '0, 0);
    drive(1, 1, 0, 4'hf, 32'h0, '0, 0);
    cnt = 0;
    for (int n = 0; n < 60 && cnt < 4; n++) begin
      @(negedge clk);
      if (p0_gnt | p1_gnt) cnt++;
    end
    check("contention_gnts", cnt, 4);
    @(posedge clk); #1;
    drive(0, 0, 0, 4'h0, '0, '0, 0);
    drive(1, 0, 0, 4'h0, '0, '0, 0);
    repeat (6) @(posedge clk); #1;
`ifdef RAM_ARB_RR_EN
    exp_log = '{0, 1, 0, 1};
`else
    exp_log = '{0, 0, 0, 0};
`endif
    check("contention_log_size", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) check("contention_winner", glog[i], exp_log[i]);

    // Word store then load.
    txn(0, 1, 4'hf, 32'h04, 32'h00000011, 0, lat, err, rd);
    check("st_word_lat", lat, 2); check("st_word_err", err, 0);
    txn(0, 0, 4'hf, 32'h04, '0, 0, lat, err, rd);
    check("ld_word_lat", lat, 3); check("ld_word_err", err, 0); check("ld_word_rdat", rd, 32'h00000011);

    // Sub-word stores and sign-extended loads.
    txn(0, 1, 4'h3, 32'h22, 32'h000000ab, 0, lat, err, rd);
    check("st_half_lat", lat, 2);
    txn(0, 0, 4'h3, 32'h22, '0, 1, lat, err, rd);
    check("ld_half_rdat", rd, 32'h000000ab);
    txn(0, 1, 4'h1, 32'h0d, 32'h000000c1, 0, lat, err, rd);
    txn(0, 0, 4'h1, 32'h0d, '0, 1, lat, err, rd);
    check("ld_byte_s_lat", lat, 3); check("ld_byte_s_rdat", rd, 32'hffffffc1);
    txn(1, 0, 4'h1, 32'h0d, '0, 0, lat, err, rd);
    check("ld_byte_u_rdat", rd, 32'h000000c1);

    // Illegal accesses: error one cycle after grant, rdat held.
    txn(1, 0, 4'hf, 32'h05, '0, 0, lat, err, rd);
    check("misaligned_lat", lat, 1); check("misaligned_err", err, 1); check("misaligned_rdat", rd, 32'h000000c1);
    txn(1, 0, 4'h5, 32'h08, '0, 0, lat, err, rd);
    check("badtype_lat", lat, 1); check("badtype_err", err, 1);
    txn(0, 0, 4'h3, 32'h0f, '0, 0, lat, err, rd);
    check("half_cross_err", err, 1); check("half_cross_rdat", rd, 32'hffffffc1);

    // Three-quarter accesses at the legal boundary.
    txn(0, 1, 4'h7, 32'h45, 32'h00123456, 0, lat, err, rd);
    check("st_3q_lat", lat, 2); check("st_3q_err", err, 0);
    txn(0, 0, 4'h7, 32'h45, '0, 1, lat, err, rd);
    check("ld_3q_rdat", rd, 32'h00123456);
    txn(1, 1, 4'h7, 32'h44, 32'h00f00001, 0, lat, err, rd);
    txn(1, 0, 4'h7, 32'h44, '0, 1, lat, err, rd);
    check("ld_3q_s_err", err, 0); check("ld_3q_s_rdat", rd, 32'hfff00001);

    // Reset in RD_WAIT aborts the load with no done.
    drive(0, 1, 0, 4'hf, 32'h04, '0, 0);
    cnt = 0;
    for (int n = 0; n < 20 && cnt == 0; n++) begin
      @(negedge clk);
      if (p0_gnt) cnt = 1;
    end
    check("rst_load_gnt", cnt, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 4'h0, '0, '0, 0);
    @(posedge clk); #1;
    check("rd_wait_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_outs", {busy, p0_done, ram_re, ram_we}, '0);
    check("async_rst_rdat", p0_rdat, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    txn(0, 0, 4'hf, 32'h04, '0, 0, lat, err, rd);
    check("post_rst_lat", lat, 3); check("post_rst_err", err, 0); check("post_rst_rdat", rd, 32'h00000011);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
